nibble_serial_sub_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_SUB_CTRL -- requirements
Module: nibble_serial_sub_ctrl

Interface
REQ-001 SHALL have one parameter: NIBBLES, default 4, giving the operand width in 4-bit nibbles (W = 4*NIBBLES).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, width 1: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-005 SHALL have port start, input, width 1: request to begin a subtraction, sampled on the clk edge.
REQ-006 SHALL have port A, input, width W: minuend, unsigned, sampled only on the start-accept edge.
REQ-007 SHALL have port B, input, width W: subtrahend, unsigned, sampled only on the start-accept edge.
REQ-008 SHALL have port busy, output, width 1: high while nibbles are being processed.
REQ-009 SHALL have port done, output, width 1: one-cycle pulse marking a valid result.
REQ-010 SHALL have port D, output, width W: difference A-B modulo 2^W.
REQ-011 SHALL have port Bout, output, width 1: final borrow, 1 iff A<B (unsigned).
REQ-012 SHALL have port zero, output, width 1: 1 iff D==0.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL use these transitions: IDLE->RUN on start; RUN->DONE after the last nibble; DONE->RUN on start, else DONE->IDLE.
REQ-015 SHALL, on start accept, latch A and B into shift registers, clear the borrow flop to 0, and clear the nibble counter to 0.
REQ-016 SHALL, in each RUN cycle, subtract the low nibble of the shifted A, the low nibble of the shifted B and the borrow flop through one 4-bit slice, then store the slice borrow in the borrow flop.
REQ-017 SHALL shift each result nibble into the D register from the MSB end, so that nibble 0 ends up at D[3:0].
REQ-018 SHALL process nibbles LSB first, one per clock, so busy is high for exactly NIBBLES cycles after the accept edge.
REQ-019 SHALL assert done for exactly one cycle, the cycle after the last RUN cycle; busy and done are never high together.
REQ-020 SHALL present valid D, Bout and zero whenever done=1, and SHALL hold them stable until the next start is accepted.
REQ-021 SHALL ignore start while in RUN: operands are not resampled and the sequence is not disturbed.
REQ-022 SHALL accept start asserted in DONE on that edge, with no idle cycle in between.
REQ-023 SHALL compute zero from the final D register (registered), not from intermediate nibbles.
REQ-024 SHALL wrap D modulo 2^W; the borrow from the top nibble goes only to Bout.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, force state=IDLE, busy=0, done=0, D=0, Bout=0, zero=1, borrow flop=0 and counter=0.
REQ-026 SHALL give rst priority over start; a reset mid-RUN abandons the operation and produces no done pulse.

Structure
REQ-027 SHALL place the FSM state encoding, the NIBBLES default and a counter-width constant (clog2 of NIBBLES, minimum 1) in a shared package, sub_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module, fs4_slice: a 4-bit subtractor with borrow-in and borrow-out, built from four 1-bit full adders (B inverted, carry-in = ~borrow-in).
REQ-029 SHALL contain no other arithmetic; the counter increments only.

Verification
REQ-030 SHALL cover: A=0x0003, B=0x0005 -> after 4 busy cycles, done pulse with D=0xFFFE, Bout=1, zero=0.
REQ-031 SHALL cover: A=0x000F, B=0x000A -> D=0x0005, Bout=0; A=0x000F, B=0x000F -> D=0x0000, Bout=0, zero=1.
REQ-032 SHALL cover cross-nibble ripple: A=0x1000, B=0x0001 -> D=0x0FFF, Bout=0; A=0x0000, B=0xFFFF -> D=0x0001, Bout=1.
REQ-033 SHALL cover start pulsed with new operands during RUN -> ignored, result matches the first operands, exactly one done.
REQ-034 SHALL cover back-to-back: start held through DONE with A=0x0008, B=0x0002 -> second run starts immediately, D=0x0006.
REQ-035 SHALL cover rst asserted in the 2nd RUN cycle -> next cycle IDLE, all outputs at reset values, no done; a later start completes correctly.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants for the nibble-serial subtractor: FSM encoding,
// default operand size and the nibble-counter width helper.
package sub_pkg;

   localparam int NIBBLES_DEF = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // A single-nibble operand still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int CNT_W_DEF = cnt_width(NIBBLES_DEF);

endpackage

// File: rtl/fs4_slice.sv
// 4-bit subtract slice: a - b - bin built from four full adders
// (b inverted, carry-in = ~bin, borrow-out = ~carry-out).
module fs4_slice (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_bin,
   output logic [3:0] o_d,
   output logic       o_bout
);

   logic [4:0] w_carry;
   logic [3:0] w_bn;

   // ripple-carry chain over the inverted subtrahend
   always_comb begin
      w_carry    = 5'd0;
      o_d        = 4'd0;
      w_bn       = ~i_b;
      w_carry[0] = ~i_bin;
      for (int k = 0; k < 4; k++) begin
         o_d[k]       = i_a[k] ^ w_bn[k] ^ w_carry[k];
         w_carry[k+1] = (i_a[k] & w_bn[k]) | (w_carry[k] & (i_a[k] ^ w_bn[k]));
      end
      o_bout = ~w_carry[4];
   end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Serial unsigned subtractor: D = A - B mod 2^W, one nibble per clock,
// LSB first, with final borrow and a registered zero flag.
module nibble_serial_sub_ctrl
   import sub_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] D,
   output logic                 Bout,
   output logic                 zero
);

   localparam int                W     = 4 * NIBBLES;
   localparam int                CNT_W = cnt_width(NIBBLES);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NIBBLES - 1);

   logic [1:0]       r_state;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_d;
   logic             r_borrow;
   logic             r_bout;
   logic             r_zero;
   logic [CNT_W-1:0] r_cnt;

   logic [3:0]       w_diff;
   logic             w_slice_bout;
   logic [W+3:0]     w_d_cat;
   logic [W-1:0]     w_d_next;

   fs4_slice u_slice (
      .i_a    (r_a[3:0]),
      .i_b    (r_b[3:0]),
      .i_bin  (r_borrow),
      .o_d    (w_diff),
      .o_bout (w_slice_bout)
   );

   // New nibble enters at the MSB end so nibble 0 settles in D[3:0].
   assign w_d_cat  = {w_diff, r_d};
   assign w_d_next = w_d_cat[W+3:4];

   // FSM, operand shifters, result register and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_d      <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b1;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_a      <= r_a >> 3'd4;
               r_b      <= r_b >> 3'd4;
               r_d      <= w_d_next;
               r_borrow <= w_slice_bout;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_bout  <= w_slice_bout;
                  r_zero  <= (w_d_next == '0);
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Back-to-back accept: no idle cycle between runs.
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign D    = r_d;
   assign Bout = r_bout;
   assign zero = r_zero;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed self-checking bench for nibble_serial_sub_ctrl (NIBBLES=4).
module tb_nibble_serial_sub_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] D;
   logic        Bout;
   logic        zero;

   int total = 0;
   int bad   = 0;

   nibble_serial_sub_ctrl #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string name, input logic exp_busy, input logic exp_done);
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
         bad++;
         $display("FAIL %s: busy=%b done=%b, required busy=%b done=%b",
                  name, busy, done, exp_busy, exp_done);
      end
   endtask

   task automatic check_result(input string name, input logic [15:0] ed, input logic eb, input logic ez);
      total++;
      if (D !== ed || Bout !== eb || zero !== ez) begin
         bad++;
         $display("FAIL %s: D=%h Bout=%b zero=%b, required D=%h Bout=%b zero=%b",
                  name, D, Bout, zero, ed, eb, ez);
      end
   endtask

   // Full transaction: accept, 4 busy cycles, one done, then idle with held result.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic eb, input logic ez);
      start = 1'b1; A = a; B = b;
      tick();
      start = 1'b0; A = 16'h0000; B = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         check_status({name, "_busy"}, 1'b1, 1'b0);
         tick();
      end
      check_status({name, "_done"}, 1'b0, 1'b1);
      check_result(name, ed, eb, ez);
      tick();
      check_status({name, "_idle"}, 1'b0, 1'b0);
      check_result({name, "_hold"}, ed, eb, ez);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = 16'h0000; B = 16'h0000;
      tick();
      tick();
      check_status("reset_status", 1'b0, 1'b0);
      check_result("reset_outputs", 16'h0000, 1'b0, 1'b1);
      rst = 1'b0;
      tick();
      check_status("reset_release", 1'b0, 1'b0);
   endtask

   task automatic test_vectors();
      run_op("sub_3_5",       16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
      run_op("sub_F_A",       16'h000F, 16'h000A, 16'h0005, 1'b0, 1'b0);
      run_op("sub_F_F",       16'h000F, 16'h000F, 16'h0000, 1'b0, 1'b1);
      run_op("ripple_1000_1", 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
      run_op("ripple_0_FFFF", 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
   endtask

   task automatic test_start_during_run();
      int dones = 0;
      start = 1'b1; A = 16'h1234; B = 16'h0034;
      tick();
      start = 1'b0; A = 16'h0000; B = 16'h0000;
      tick();
      start = 1'b1; A = 16'hFFFF; B = 16'h0000;
      tick();
      start = 1'b0; A = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (done) begin
            dones++;
            check_result("ignore_result", 16'h1200, 1'b0, 1'b0);
         end
         tick();
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL ignore_done_count: got %0d done pulses, required 1", dones);
      end
      check_status("ignore_idle", 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      start = 1'b1; A = 16'h0010; B = 16'h0001;
      tick();
      A = 16'h0008; B = 16'h0002;
      for (int i = 0; i < 4; i++) tick();
      check_status("b2b_first_done", 1'b0, 1'b1);
      check_result("b2b_first", 16'h000F, 1'b0, 1'b0);
      tick();
      start = 1'b0; A = 16'h0000; B = 16'h0000;
      check_status("b2b_restart", 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check_status("b2b_last_busy", 1'b1, 1'b0);
      tick();
      check_status("b2b_second_done", 1'b0, 1'b1);
      check_result("b2b_second", 16'h0006, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; A = 16'h5555; B = 16'h1111;
      tick();
      start = 1'b0; A = 16'h0000; B = 16'h0000;
      tick();
      check_status("mid_second_run", 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_status("mid_reset_status", 1'b0, 1'b0);
      check_result("mid_reset_outputs", 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check_status("mid_no_done", 1'b0, 1'b0);
         tick();
      end
      run_op("after_reset", 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = 16'h0000; B = 16'h0000;
      test_reset();
      test_vectors();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
